// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared constants, state type and lane-pick helpers for mux4_rr_arbiter
package mux_arb_pkg;

  localparam int NUM_LANES = 4;
  localparam int SEL_W     = 2;

  // Pointer value whose successor is lane 0; used at reset and as the fixed-priority origin.
  localparam logic [SEL_W-1:0] PTR_RESET = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Winner is the first requester at ptr+1, ptr+2, ptr+3, ptr (mod 4); returns ptr when nothing requests.
  function automatic logic [SEL_W-1:0] next_lane(input logic [SEL_W-1:0] ptr,
                                                 input logic [NUM_LANES-1:0] req);
    logic [SEL_W-1:0] cand;
    next_lane = ptr;
    for (int k = NUM_LANES; k >= 1; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) next_lane = cand;
    end
  endfunction

  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [SEL_W-1:0] idx);
    lane_onehot      = '0;
    lane_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational 4-lane picker searching from the lane after ptr
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NUM_LANES-1:0] req,
  input  logic [SEL_W-1:0]     ptr,
  output logic [SEL_W-1:0]     idx,
  output logic                 any
);

  assign idx = next_lane(ptr, req);
  assign any = |req;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter sharing one 4:1 data mux among four lanes
// MUX_ARB_FIXED_PRIO_EN: fixed priority (lane 0 highest) instead of round-robin
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DW       = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_LANES-1:0]    req,
  input  logic [NUM_LANES*DW-1:0] din,
  input  logic [NUM_LANES-1:0]    last,
  output logic [NUM_LANES-1:0]    gnt,
  output logic [SEL_W-1:0]        sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DW-1:0]           out_data,
  output logic                    out_last
);

  localparam int               CNT_W    = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  arb_state_t           state, state_nxt;
  logic [SEL_W-1:0]     sel_nxt;
  logic [NUM_LANES-1:0] gnt_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [SEL_W-1:0]     pick_ptr, pick_idx;
  logic                 pick_any;
  logic                 xfer, beat_end, release_now;
  logic [DW-1:0]        lane_data [NUM_LANES];

`ifdef MUX_ARB_FIXED_PRIO_EN
  assign pick_ptr = PTR_RESET;
`else
  logic [SEL_W-1:0] ptr;

  always_ff @(posedge clk) begin
    if (rst)              ptr <= PTR_RESET;
    else if (release_now) ptr <= sel;
  end

  assign pick_ptr = ptr;
`endif

  rr_pick4 u_pick (
    .req (req),
    .ptr (pick_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_data[i] = din[i*DW +: DW];
  end

  // Everything downstream follows the registered sel, so the mux select never glitches on req.
  assign out_valid   = (state == BUSY) && req[sel];
  assign out_data    = out_valid ? lane_data[sel] : '0;
  assign beat_end    = last[sel] || (cnt == CNT_LAST);
  assign out_last    = out_valid && beat_end;
  assign xfer        = out_valid && out_ready;
  assign release_now = (state == BUSY) && ((xfer && beat_end) || !req[sel]);

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    gnt_nxt   = gnt;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = BUSY;
          sel_nxt   = pick_idx;
          gnt_nxt   = lane_onehot(pick_idx);
          cnt_nxt   = '0;
        end
      end
      BUSY: begin
        if (release_now) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          cnt_nxt   = '0;
        end else if (xfer) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel   <= '0;
      gnt   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      gnt   <= gnt_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - directed self-checking bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;

  localparam int DW       = 8;
  localparam int HOLD_MAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req;
  logic [4*DW-1:0] din;
  logic [3:0]    last;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  int vectors     = 0;
  int miscompares = 0;

  mux4_rr_arbiter #(.DW(DW), .HOLD_MAX(HOLD_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .din       (din),
    .last      (last),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".gnt"}, 32'(gnt), 32'h0);
    check({tag, ".valid"}, 32'(out_valid), 32'h0);
    check({tag, ".data"}, 32'(out_data), 32'h0);
    check({tag, ".last"}, 32'(out_last), 32'h0);
  endtask

  task automatic check_grant(input string tag, input int lane);
    check({tag, ".gnt"}, 32'(gnt), 32'(4'b0001 << lane));
    check({tag, ".sel"}, 32'(sel), 32'(lane));
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1; req = 4'b0000; last = 4'b0000; out_ready = 1'b0;
    din = {8'h13, 8'h12, 8'h11, 8'h10};
    tick(); tick();
    rst = 1'b0;
    #1;
    check_idle("reset");
    check("reset.sel", 32'(sel), 32'h0);

    // Single-beat packet on lane 0
    din[7:0] = 8'hA5; last = 4'b0001; req = 4'b0001; out_ready = 1'b1;
    tick();
    check_grant("t1", 0);
    check("t1.valid", 32'(out_valid), 32'h1);
    check("t1.data", 32'(out_data), 32'hA5);
    check("t1.last", 32'(out_last), 32'h1);
    tick();
    req = 4'b0000;
    #1;
    check_idle("t1.rel");
    din[7:0] = 8'h10;

    // Round-robin rotation from reset pointer
    rst = 1'b1;
    tick();
    rst = 1'b0; req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_grant("t2.grant", order[k]);
      check("t2.data", 32'(out_data), 32'(8'h10 + order[k]));
      tick();
      check("t2.gap", 32'(gnt), 32'h0);
    end

    // Lane 2 alone, HOLD_MAX limit then re-grant
    req = 4'b0100; last = 4'b0000;
    for (int b = 0; b < HOLD_MAX; b++) begin
      tick();
      check_grant("t3.beat", 2);
      check("t3.valid", 32'(out_valid), 32'h1);
      check("t3.last", 32'(out_last), 32'(b == HOLD_MAX - 1));
    end
    tick();
    check_idle("t3.rel");
    tick();
    check_grant("t3.regrant", 2);
    req = 4'b0000; out_ready = 1'b0;
    tick();
    check_idle("t3.withdraw");

    // Lane 1 stalled by out_ready=0; beat count starts at first accepted beat
    req = 4'b0010;
    tick();
    for (int s = 0; s < 5; s++) begin
      check_grant("t4.stall", 1);
      check("t4.valid", 32'(out_valid), 32'h1);
      check("t4.data", 32'(out_data), 32'h11);
      check("t4.last", 32'(out_last), 32'h0);
      if (s < 4) tick();
    end
    out_ready = 1'b1;
    for (int b = 0; b < HOLD_MAX; b++) begin
      if (b > 0) tick();
      #1;
      check("t4.beat_last", 32'(out_last), 32'(b == HOLD_MAX - 1));
    end
    req = 4'b0000;
    tick();
    check_idle("t4.rel");

    // Lane 3 withdraws after 2 beats; lane 0 wins next from ptr=3
    req = 4'b1001;
    tick();
    check_grant("t5.grant", 3);
    tick();
    tick();
    req = 4'b0001;
    #1;
    check("t5.wd_valid", 32'(out_valid), 32'h0);
    check("t5.wd_last", 32'(out_last), 32'h0);
    check("t5.wd_data", 32'(out_data), 32'h0);
    tick();
    check_idle("t5.rel");
    tick();
    check_grant("t5.next", 0);

    // Reset mid-grant
    out_ready = 1'b0;
    #1;
    check("t6.valid_pre", 32'(out_valid), 32'h1);
    rst = 1'b1;
    tick();
    check_idle("t6.rst");
    check("t6.sel", 32'(sel), 32'h0);
    rst = 1'b0; req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
    tick();
    check_grant("t6.ptr3", 0);

    // req=1010: lane 1 always in fixed priority, alternates 1/3 in round-robin
    req = 4'b1010;
    tick();
    check("t7.withdraw", 32'(gnt), 32'h0);
    tick();
    check_grant("t7.first", 1);
    tick();
    check("t7.gap1", 32'(gnt), 32'h0);
    tick();
`ifdef MUX_ARB_FIXED_PRIO_EN
    check_grant("t7.second", 1);
`else
    check_grant("t7.second", 3);
`endif
    tick();
    check("t7.gap2", 32'(gnt), 32'h0);
    tick();
    check_grant("t7.third", 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
